// File: rtl/knights_tour_solver.sv
// rtl/knights_tour_solver.sv - backtracking 5x5 knight's tour solver with one-hot move store
module knights_tour_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [2:0] x_start,
    input  logic [2:0] y_start,
    input  logic [4:0] move_indx,
    output logic [7:0] move,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    typedef enum logic [2:0] {IDLE, INIT, POSSIBLE, MAKE_MOVE, BACKUP, DONE, FAIL} state_t;

    state_t      state;
    logic [24:0] board;
    logic [7:0]  move_mem [0:23];
    logic [7:0]  poss_mem [0:23];
    logic [7:0]  try_r;
    logic [4:0]  move_num;
    logic [2:0]  xx, yy;

    function automatic logic signed [3:0] dx_of(input logic [2:0] k);
        case (k)
            3'd0, 3'd5: return -4'sd1;
            3'd1, 3'd4: return 4'sd1;
            3'd2, 3'd3: return 4'sd2;
            default:    return -4'sd2;
        endcase
    endfunction

    function automatic logic signed [3:0] dy_of(input logic [2:0] k);
        case (k)
            3'd0, 3'd1: return 4'sd2;
            3'd2, 3'd7: return 4'sd1;
            3'd3, 3'd6: return -4'sd1;
            default:    return -4'sd2;
        endcase
    endfunction

    function automatic logic [7:0] legal_moves(input logic [2:0] x, input logic [2:0] y);
        logic signed [3:0] nx, ny;
        logic [7:0]        m;
        m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            nx = $signed({1'b0, x}) + dx_of(3'(k));
            ny = $signed({1'b0, y}) + dy_of(3'(k));
            m[k] = (nx >= 4'sd0) && (nx <= 4'sd4) && (ny >= 4'sd0) && (ny <= 4'sd4);
        end
        return m;
    endfunction

    function automatic logic [2:0] idx_of(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++)
            if (oh[k]) r = 3'(k);
        return r;
    endfunction

    function automatic logic [4:0] sq(input logic [2:0] x, input logic [2:0] y);
        return {2'b00, y} * 5'd5 + {2'b00, x};
    endfunction

    logic [2:0]        try_idx, last_idx;
    logic signed [3:0] tx, ty, bx, by;
    logic [4:0]        target, cur_sq;
    logic [7:0]        last, poss_cur;
    logic [31:0]       board_ext;
    logic              cand_ok;

    always_comb begin
        try_idx   = idx_of(try_r);
        tx        = $signed({1'b0, xx}) + dx_of(try_idx);
        ty        = $signed({1'b0, yy}) + dy_of(try_idx);
        target    = sq(tx[2:0], ty[2:0]);
        cur_sq    = sq(xx, yy);
        board_ext = {7'b0, board};
        poss_cur  = poss_mem[move_num];
        // Out-of-bounds candidates are already masked off by poss_cur
        cand_ok   = (|(poss_cur & try_r)) && (target < 5'd25) && !board_ext[target];
        last      = (move_num != 5'd0) ? move_mem[move_num - 5'd1] : 8'h00;
        last_idx  = idx_of(last);
        bx        = $signed({1'b0, xx}) - dx_of(last_idx);
        by        = $signed({1'b0, yy}) - dy_of(last_idx);
    end

    assign move = (move_indx < 5'd24) ? move_mem[move_indx] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            board    <= '0;
            try_r    <= 8'h00;
            move_num <= '0;
            xx       <= '0;
            yy       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            for (int i = 0; i < 24; i++) begin
                move_mem[i] <= 8'h00;
                poss_mem[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (state == DONE) done <= 1'b1;
                    if (state == FAIL) fail <= 1'b1;
                    if (go) begin
                        xx   <= x_start;
                        yy   <= y_start;
                        done <= 1'b0;
                        fail <= 1'b0;
                        if (x_start > 3'd4 || y_start > 3'd4) begin
                            state <= FAIL;
                        end else begin
                            state <= INIT;
                            busy  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    board    <= 25'd1 << cur_sq;
                    move_num <= '0;
                    state    <= POSSIBLE;
                end
                POSSIBLE: begin
                    poss_mem[move_num] <= legal_moves(xx, yy);
                    try_r              <= 8'h01;
                    state              <= MAKE_MOVE;
                end
                MAKE_MOVE: begin
                    if (cand_ok) begin
                        move_mem[move_num] <= try_r;
                        xx                 <= tx[2:0];
                        yy                 <= ty[2:0];
                        board[target]      <= 1'b1;
                        if (move_num == 5'd23) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            move_num <= move_num + 5'd1;
                            state    <= POSSIBLE;
                        end
                    end else if (try_r != 8'h80) begin
                        try_r <= try_r << 1;
                    end else begin
                        state <= BACKUP;
                    end
                end
                BACKUP: begin
                    if (move_num == 5'd0) begin
                        state <= FAIL;
                        busy  <= 1'b0;
                    end else begin
                        board[cur_sq] <= 1'b0;
                        xx            <= bx[2:0];
                        yy            <= by[2:0];
                        move_num      <= move_num - 5'd1;
                        // A retracted b7 has no successor to try, so keep unwinding
                        if (last != 8'h80) begin
                            try_r <= last << 1;
                            state <= MAKE_MOVE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knights_tour_solver.sv
// tb/tb_knights_tour_solver.sv - self-checking bench for knights_tour_solver
module tb_knights_tour_solver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic [2:0] x_start = 3'd0;
    logic [2:0] y_start = 3'd0;
    logic [4:0] move_indx = 5'd0;
    logic [7:0] move;
    logic       busy, done, fail;

    knights_tour_solver dut (
        .clk(clk), .rst_n(rst_n), .go(go), .x_start(x_start), .y_start(y_start),
        .move_indx(move_indx), .move(move), .busy(busy), .done(done), .fail(fail)
    );

    always #10 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int dxs[8];
    int dys[8];
    int exp_k[24];
    bit exp_ok;
    int exp_work;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        bit         fail_at_1;
        bit         fail_at_2;
    } bad_vec_t;
    bad_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Plain depth-first search over board coordinates, same candidate order b0..b7.
    task automatic model_solve(input int sx, input int sy);
        int vis[25];
        int px[25], py[25], nk[25];
        int d, k, nx, ny;
        bit found;
        foreach (vis[i]) vis[i] = 0;
        px[0] = sx; py[0] = sy; nk[0] = 0; d = 0;
        vis[sy * 5 + sx] = 1;
        exp_ok = 0; exp_work = 1;
        while (1) begin
            if (d == 24) begin exp_ok = 1; break; end
            found = 0;
            k = nk[d];
            nx = 0; ny = 0;
            while (k < 8 && !found) begin
                exp_work++;
                nx = px[d] + dxs[k];
                ny = py[d] + dys[k];
                if (nx >= 0 && nx <= 4 && ny >= 0 && ny <= 4 && vis[ny * 5 + nx] == 0)
                    found = 1;
                else
                    k++;
            end
            if (found) begin
                exp_k[d] = k; nk[d] = k + 1;
                vis[ny * 5 + nx] = 1;
                d++;
                px[d] = nx; py[d] = ny; nk[d] = 0;
                exp_work++;
            end else begin
                if (d == 0) break;
                vis[py[d] * 5 + px[d]] = 0;
                d--;
                exp_work++;
            end
        end
    endtask

    task automatic pulse_go(input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        x_start = x; y_start = y; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic read_mv(input int i, output logic [7:0] v);
        move_indx = 5'(i);
        #1;
        v = move;
    endtask

    task automatic wait_result(input int budget);
        int n = 0;
        while (!(done || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("finish_within_budget", 32'(done || fail), 32'd1);
    endtask

    task automatic check_tour(input int sx, input int sy);
        int vis[25];
        int x, y, nx, ny, cnt, k;
        logic [7:0] v;
        bit legal;
        foreach (vis[i]) vis[i] = 0;
        x = sx; y = sy; vis[y * 5 + x] = 1; cnt = 1;
        for (int i = 0; i < 24; i++) begin
            read_mv(i, v);
            legal = $onehot(v);
            k = 0;
            for (int b = 0; b < 8; b++) if (v[b]) k = b;
            nx = x + dxs[k]; ny = y + dys[k];
            legal = legal && nx >= 0 && nx <= 4 && ny >= 0 && ny <= 4;
            if (legal) legal = (vis[ny * 5 + nx] == 0);
            if (legal) begin vis[ny * 5 + nx] = 1; cnt++; x = nx; y = ny; end
            chk("tour_move_legal", 32'(legal), 32'd1);
            chk("tour_move_vs_model", 32'(v), 32'(1 << exp_k[i]));
        end
        chk("tour_squares_visited", cnt, 25);
    endtask

    initial begin
        logic [7:0] v;
        int idx, dly;
        dxs = '{-1, 1, 2, 2, 1, -1, -2, -2};
        dys = '{2, 2, 1, -1, -2, -2, -1, 1};
        vecs[0] = '{3'd5, 3'd2, 1'b0, 1'b1};
        vecs[1] = '{3'd2, 3'd7, 1'b0, 1'b1};
        vecs[2] = '{3'd7, 3'd7, 1'b0, 1'b1};
        vecs[3] = '{3'd0, 3'd5, 1'b0, 1'b1};
        vecs[4] = '{3'($urandom_range(5, 7)), 3'($urandom_range(0, 7)), 1'b0, 1'b1};
        vecs[5] = '{3'($urandom_range(0, 7)), 3'($urandom_range(5, 7)), 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_fail", 32'(fail), 32'd0);
        repeat (3) begin
            read_mv($urandom_range(0, 23), v);
            chk("reset_move_store", 32'(v), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Tour from a corner
        model_solve(0, 0);
        pulse_go(3'd0, 3'd0);
        chk("busy_after_go", 32'(busy), 32'd1);
        wait_result(2 * exp_work + 200);
        chk("corner_done", 32'(done), 32'd1);
        chk("corner_fail", 32'(fail), 32'd0);
        chk("corner_busy", 32'(busy), 32'd0);
        check_tour(0, 0);
        repeat (6) begin
            idx = $urandom_range(0, 23);
            read_mv(idx, v);
            chk("random_read", 32'(v), 32'(1 << exp_k[idx]));
        end

        // Off-board starts fail two cycles after go and leave the store alone
        for (int i = 0; i < 6; i++) begin
            pulse_go(vecs[i].x, vecs[i].y);
            chk("bad_start_fail_cycle1", 32'(fail), 32'(vecs[i].fail_at_1));
            chk("bad_start_done_cleared", 32'(done), 32'd0);
            @(negedge clk);
            chk("bad_start_fail_cycle2", 32'(fail), 32'(vecs[i].fail_at_2));
            chk("bad_start_busy", 32'(busy), 32'd0);
            idx = $urandom_range(0, 23);
            read_mv(idx, v);
            chk("bad_start_store_kept", 32'(v), 32'(1 << exp_k[idx]));
        end

        // Centre start with a stray go while busy
        model_solve(2, 2);
        pulse_go(3'd2, 3'd2);
        dly = $urandom_range(3, 40);
        repeat (dly) @(negedge clk);
        chk("busy_before_2nd_go", 32'(busy), 32'd1);
        pulse_go(3'd0, 3'd0);
        wait_result(2 * exp_work + 200);
        chk("centre_done", 32'(done), 32'd1);
        chk("centre_fail", 32'(fail), 32'd0);
        check_tour(2, 2);

        // Reset in the middle of an exhaustive search, then a fresh solve
        pulse_go(3'd0, 3'd1);
        repeat ($urandom_range(100, 400)) @(negedge clk);
        chk("odd_start_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_fail", 32'(fail), 32'd0);
        read_mv(0, v);
        chk("midreset_move0", 32'(v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_go(3'd2, 3'd2);
        wait_result(2 * exp_work + 200);
        chk("after_reset_done", 32'(done), 32'd1);
        check_tour(2, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
